// File: rtl/bp_pkg.sv
// bp_pkg: shared types and counter helpers for the local branch predictor.
// Counter helpers work on 32-bit values; callers size-cast to their counter width.
package bp_pkg;

    localparam int REC_IDX_W = 16;

    typedef struct packed {
        logic                 pred;
        logic [REC_IDX_W-1:0] p_idx;
        logic [REC_IDX_W-1:0] bht_idx;
    } bp_rec_t;

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [31:0] CNT_RST(input int cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int cnt_w);
        logic [31:0] max_v;
        max_v = (32'd1 << cnt_w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/bp_pht_bank.sv
// bp_pht_bank: pattern history table of saturating counters.
// One asynchronous read port and one synchronous read-modify-write update port.
module bp_pht_bank
    import bp_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(CNT_RST(CNT_W));

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_nxt;

    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign cnt_cur  = cnt_q[wr_idx_i];
    assign cnt_nxt  = wr_taken_i ? CNT_W'(sat_inc(32'(cnt_cur), CNT_W))
                                 : CNT_W'(sat_dec(32'(cnt_cur)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= RST_VAL;
            end
        end else if (we_i) begin
            cnt_q[wr_idx_i] <= cnt_nxt;
        end
    end

endmodule

// File: rtl/branch_predict_local_param.sv
// branch_predict_local_param: two-level local predictor, BHT histories index a PHT of counters.
// Define BP_STATS_EN to add saturating branch and mispredict counters.
module branch_predict_local_param
    import bp_pkg::*;
#(
    parameter int BHT_IDX_W = 4,
    parameter int HIST_W    = 4,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic [31:0] pcF,
    input  logic        branchD,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        pred_resM
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int BHT_DEPTH = 1 << BHT_IDX_W;

    logic [HIST_W-1:0]    bht_q [BHT_DEPTH];
    logic [BHT_IDX_W-1:0] bht_idxF;
    logic [HIST_W-1:0]    histF;
    logic [HIST_W-1:0]    p_idxF;
    logic [CNT_W-1:0]     cntF;
    bp_rec_t              recF;
    bp_rec_t              recD_d;
    bp_rec_t              recD_q;
    bp_rec_t              recE_q;
    bp_rec_t              recM_q;
    logic [HIST_W-1:0]    p_idxM;
    logic [BHT_IDX_W-1:0] bht_idxM;
    logic [HIST_W-1:0]    histM;
    logic                 unused_bits;

    assign bht_idxF = pcF[BHT_IDX_W+1:2];
    assign histF    = bht_q[bht_idxF];
    assign p_idxF   = histF ^ pcF[HIST_W+1:2];

    assign p_idxM   = recM_q.p_idx[HIST_W-1:0];
    assign bht_idxM = recM_q.bht_idx[BHT_IDX_W-1:0];
    assign histM    = bht_q[bht_idxM];

    assign unused_bits = ^{recM_q.p_idx, recM_q.bht_idx, pcF};

    bp_pht_bank #(
        .IDX_W (HIST_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (p_idxF),
        .rd_cnt_o   (cntF),
        .we_i       (branchM),
        .wr_idx_i   (p_idxM),
        .wr_taken_i (actual_takeM)
    );

    always_comb begin
        recF         = '0;
        recF.pred    = cntF[CNT_W-1];
        recF.p_idx   = REC_IDX_W'(p_idxF);
        recF.bht_idx = REC_IDX_W'(bht_idxF);
    end

    // Flush takes priority over stall on the F->D record.
    always_comb begin
        recD_d = recF;
        if (flushD) begin
            recD_d = '0;
        end else if (stallD) begin
            recD_d = recD_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recD_q <= '0;
            recE_q <= '0;
            recM_q <= '0;
        end else begin
            recD_q <= recD_d;
            recE_q <= flushE ? '0 : recD_q;
            recM_q <= flushM ? '0 : recE_q;
        end
    end

    // History is only shifted at resolution, so fetch never sees speculative outcomes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= '0;
            end
        end else if (branchM) begin
            bht_q[bht_idxM] <= {histM[HIST_W-2:0], actual_takeM};
        end
    end

    assign pred_takeD = branchD & recD_q.pred;
    assign pred_resM  = rst & branchM & (recM_q.pred != actual_takeM);

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (branchM) begin
                stat_branches_q <= sat_inc(stat_branches_q, 32);
            end
            if (pred_resM) begin
                stat_mispred_q <= sat_inc(stat_mispred_q, 32);
            end
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predict_local_param.sv
// tb_branch_predict_local_param: directed scenarios for the local predictor (CNT_W=2 and CNT_W=3 instances).
// Stats checks are compiled in only when BP_STATS_EN is defined.
module tb_branch_predict_local_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic [31:0] pcF;
    logic        branchD;
    logic        branchM;
    logic        actual_takeM;
    logic        pred_takeD;
    logic        pred_resM;
    logic        pred_takeD3;
    logic        pred_resM3;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    logic [31:0] stat_branches3;
    logic [31:0] stat_mispred3;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    branch_predict_local_param dut (
        .clk          (clk),
        .rst          (rst),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .pcF          (pcF),
        .branchD      (branchD),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeD   (pred_takeD),
        .pred_resM    (pred_resM)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    branch_predict_local_param #(
        .BHT_IDX_W (4),
        .HIST_W    (4),
        .CNT_W     (3)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .pcF          (pcF),
        .branchD      (branchD),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeD   (pred_takeD3),
        .pred_resM    (pred_resM3)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches3),
        .stat_mispred  (stat_mispred3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst          = 1'b0;
        stallD       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        pcF          = 32'h0;
        branchD      = 1'b0;
        branchM      = 1'b0;
        actual_takeM = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // One branch fetched at pc and walked alone through D, E and M.
    task automatic applyStimulus(input logic [31:0] pc, input logic taken,
                                 output logic seenD, output logic seenM);
        pcF          = pc;
        branchD      = 1'b0;
        branchM      = 1'b0;
        actual_takeM = 1'b0;
        tick();
        branchD = 1'b1;
        #1;
        seenD = pred_takeD;
        tick();
        branchD = 1'b0;
        tick();
        branchM      = 1'b1;
        actual_takeM = taken;
        #1;
        seenM = pred_resM;
        tick();
        branchM      = 1'b0;
        actual_takeM = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        stallD       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        pcF          = 32'h40;
        branchD      = 1'b1;
        branchM      = 1'b1;
        actual_takeM = 1'b1;
        #2;
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pred_takeD: got %b, expected 0", pred_takeD);
        end
        testsRun++;
        if (pred_resM !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pred_resM: got %b, expected 0", pred_resM);
        end
        testsRun++;
        if ({pred_takeD3, pred_resM3} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_cnt3_outputs: got %b, expected 00", {pred_takeD3, pred_resM3});
        end
        tick();
        tick();
        rst          = 1'b1;
        branchD      = 1'b0;
        branchM      = 1'b0;
        actual_takeM = 1'b0;
        pcF          = 32'h40;
        tick();
        branchD = 1'b1;
        #1;
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL first_lookup: got %b, expected 0", pred_takeD);
        end
`ifdef BP_STATS_EN
        testsRun++;
        if ({stat_branches, stat_mispred} !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_stats: got %0d/%0d, expected 0/0", stat_branches, stat_mispred);
        end
`endif
    endtask

    task automatic test_training();
        logic       d;
        logic       m;
        logic [7:0] expD;
        logic [7:0] expM;
        expD = 8'b1110_0000;
        expM = 8'b0001_1111;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h40, 1'b1, d, m);
            testsRun++;
            if (d !== expD[i]) begin
                testsFailed++;
                $display("[TB] FAIL train_pred_takeD[%0d]: got %b, expected %b", i, d, expD[i]);
            end
            testsRun++;
            if (m !== expM[i]) begin
                testsFailed++;
                $display("[TB] FAIL train_pred_resM[%0d]: got %b, expected %b", i, m, expM[i]);
            end
        end
`ifdef BP_STATS_EN
        testsRun++;
        if (stat_branches !== 32'd8 || stat_mispred !== 32'd5) begin
            testsFailed++;
            $display("[TB] FAIL train_stats: got %0d/%0d, expected 8/5", stat_branches, stat_mispred);
        end
`endif
    endtask

    task automatic test_flush_stall();
        logic [31:0] stallPcs [3];
        stallPcs[0] = 32'h48;
        stallPcs[1] = 32'h50;
        stallPcs[2] = 32'h54;
        pcF     = 32'h40;
        branchD = 1'b1;
        tick();
        testsRun++;
        if (pred_takeD !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_pre: got %b, expected 1", pred_takeD);
        end
        flushD = 1'b1;
        stallD = 1'b1;
        tick();
        flushD = 1'b0;
        stallD = 1'b0;
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_beats_stall: got %b, expected 0", pred_takeD);
        end
        tick();
        stallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pcF = stallPcs[k];
            tick();
            testsRun++;
            if (pred_takeD !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold[%0d]: got %b, expected 1", k, pred_takeD);
            end
        end
        stallD = 1'b0;
        tick();
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_release: got %b, expected 0", pred_takeD);
        end
    endtask

    task automatic test_flush_em();
        branchD = 1'b0;
        pcF     = 32'h40;
        tick();
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        tick();
        branchM      = 1'b1;
        actual_takeM = 1'b1;
        #1;
        testsRun++;
        if (pred_resM !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flushE_clears: got %b, expected 1", pred_resM);
        end
        tick();
        branchM = 1'b0;
        tick();
        tick();
        flushM = 1'b1;
        tick();
        flushM  = 1'b0;
        branchM = 1'b1;
        #1;
        testsRun++;
        if (pred_resM !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flushM_clears: got %b, expected 1", pred_resM);
        end
        tick();
        branchM      = 1'b0;
        actual_takeM = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic d;
        logic m;
        doReset();
        applyStimulus(32'h44, 1'b1, d, m);
        testsRun++;
        if (d !== 1'b0 || m !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_setup: got %b%b, expected 01", d, m);
        end
        pcF = 32'h44;
        tick();
        tick();
        tick();
        branchM      = 1'b1;
        actual_takeM = 1'b1;
        pcF          = 32'h40;
        branchD      = 1'b1;
        #1;
        testsRun++;
        if (pred_resM !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_resM: got %b, expected 1", pred_resM);
        end
        tick();
        branchM      = 1'b0;
        actual_takeM = 1'b0;
        #1;
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_old: got %b, expected 0", pred_takeD);
        end
        tick();
        testsRun++;
        if (pred_takeD !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_new: got %b, expected 1", pred_takeD);
        end
    endtask

    task automatic test_cnt3();
        doReset();
        pcF = 32'h40;
        tick();
        stallD = 1'b1;
        tick();
        tick();
        branchM      = 1'b1;
        actual_takeM = 1'b1;
        #1;
        testsRun++;
        if (pred_resM3 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL cnt3_resM: got %b, expected 1", pred_resM3);
        end
        repeat (10) tick();
        testsRun++;
        if (dut3.u_pht.cnt_q[0] !== 3'd7) begin
            testsFailed++;
            $display("[TB] FAIL cnt3_saturate: got %0d, expected 7", dut3.u_pht.cnt_q[0]);
        end
        testsRun++;
        if (dut.u_pht.cnt_q[0] !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL cnt2_saturate: got %0d, expected 3", dut.u_pht.cnt_q[0]);
        end
        actual_takeM = 1'b0;
        tick();
        branchM = 1'b0;
        testsRun++;
        if (dut3.u_pht.cnt_q[0] !== 3'd6) begin
            testsFailed++;
            $display("[TB] FAIL cnt3_dec: got %0d, expected 6", dut3.u_pht.cnt_q[0]);
        end
        testsRun++;
        if (dut.u_pht.cnt_q[0] !== 2'd2) begin
            testsFailed++;
            $display("[TB] FAIL cnt2_dec: got %0d, expected 2", dut.u_pht.cnt_q[0]);
        end
        stallD = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic d;
        logic m;
        doReset();
        repeat (5) applyStimulus(32'h40, 1'b1, d, m);
        pcF     = 32'h40;
        branchD = 1'b1;
        tick();
        stallD = 1'b1;
        tick();
        tick();
        branchM      = 1'b1;
        actual_takeM = 1'b0;
        #1;
        testsRun++;
        if ({pred_takeD, pred_resM} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL midstream_pre: got %b, expected 11", {pred_takeD, pred_resM});
        end
        #2;
        rst = 1'b0;
        #1;
        testsRun++;
        if (pred_takeD !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midstream_rst_takeD: got %b, expected 0", pred_takeD);
        end
        testsRun++;
        if (pred_resM !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midstream_rst_resM: got %b, expected 0", pred_resM);
        end
`ifdef BP_STATS_EN
        testsRun++;
        if ({stat_branches, stat_mispred} !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL midstream_stats: got %0d/%0d, expected 0/0", stat_branches, stat_mispred);
        end
`endif
        tick();
        rst          = 1'b1;
        stallD       = 1'b0;
        branchD      = 1'b0;
        branchM      = 1'b0;
        actual_takeM = 1'b0;
        applyStimulus(32'h40, 1'b1, d, m);
        testsRun++;
        if (d !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reinit_takeD: got %b, expected 0", d);
        end
        testsRun++;
        if (m !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reinit_resM: got %b, expected 1", m);
        end
`ifdef BP_STATS_EN
        testsRun++;
        if (stat_branches !== 32'd1 || stat_mispred !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL reinit_stats: got %0d/%0d, expected 1/1", stat_branches, stat_mispred);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_training();
        test_flush_stall();
        test_flush_em();
        test_same_cycle();
        test_cnt3();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
